// File: rtl/mapa_arbiter.sv
// mapa_arbiter: owner of the single-port tile-map RAM.
// It serialises update-engine reads/writes and fruit-spawner read probes
// with a round-robin choice, turns (x,y) into linear RAM addresses, and
// runs a full-map clear sweep that writes 00 to every cell.
module mapa_arbiter #(
    parameter int MAPA_WIDTH  = 40,
    parameter int MAPA_HEIGHT = 30,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_req,
    input  logic              upd_we,
    input  logic [9:0]        upd_x,
    input  logic [9:0]        upd_y,
    input  logic [1:0]        upd_wdata,
    output logic              upd_ack,
    output logic [1:0]        upd_rdata,
    input  logic              fru_req,
    input  logic [9:0]        fru_x,
    input  logic [9:0]        fru_y,
    output logic              fru_ack,
    output logic [1:0]        fru_rdata,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RDWAIT = 2'b10,
        ST_CLEAR  = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAPA_WIDTH * MAPA_HEIGHT - 1);

    // True when (x,y) lies inside the map.
    function automatic logic in_map(input logic [9:0] x, input logic [9:0] y);
        return (x < 10'(MAPA_WIDTH)) && (y < 10'(MAPA_HEIGHT));
    endfunction

    // Row-major linear address y*W + x; only meaningful for in-map coordinates.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(y) * ADDR_W'(MAPA_WIDTH) + ADDR_W'(x);
    endfunction

    state_t              state_q, state_d;
    logic                rr_q, rr_d;        // 0: favour update, 1: favour fruit
    logic                gnt_q, gnt_d;      // 0: update owns access, 1: fruit
    logic                wr_q, wr_d;        // current access is a write
    logic                oor_q, oor_d;      // current access is off the map
    logic                pend_q, pend_d;    // clear requested while busy
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          mem_wdata_q, mem_wdata_d;
    logic                upd_ack_q, upd_ack_d;
    logic [1:0]          upd_rdata_q, upd_rdata_d;
    logic                fru_ack_q, fru_ack_d;
    logic [1:0]          fru_rdata_q, fru_rdata_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;

    logic                upd_elig_s, fru_elig_s;
    logic                upd_in_s, fru_in_s;
    logic [ADDR_W-1:0]   upd_addr_s, fru_addr_s;

    // A requester acked this cycle still has req high and must not be re-served.
    assign upd_elig_s = upd_req & ~upd_ack_q;
    assign fru_elig_s = fru_req & ~fru_ack_q;
    assign upd_in_s   = in_map(upd_x, upd_y);
    assign fru_in_s   = in_map(fru_x, fru_y);
    assign upd_addr_s = upd_in_s ? lin_addr(upd_x, upd_y) : '0;
    assign fru_addr_s = fru_in_s ? lin_addr(fru_x, fru_y) : '0;

    // Next-state and registered-output computation for the access/clear FSM.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        wr_d         = wr_q;
        oor_d        = oor_q;
        pend_d       = pend_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        upd_ack_d    = 1'b0;
        upd_rdata_d  = upd_rdata_q;
        fru_ack_d    = 1'b0;
        fru_rdata_d  = fru_rdata_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_q || clear_start) begin
                    pend_d       = 1'b0;
                    mem_addr_d   = '0;
                    mem_we_d     = 1'b1;
                    mem_wdata_d  = 2'b00;
                    clear_busy_d = 1'b1;
                    state_d      = ST_CLEAR;
                end else if (upd_elig_s && (!fru_elig_s || !rr_q)) begin
                    gnt_d       = 1'b0;
                    rr_d        = 1'b1;
                    wr_d        = upd_we;
                    oor_d       = ~upd_in_s;
                    mem_addr_d  = upd_addr_s;
                    mem_we_d    = upd_we & upd_in_s;
                    mem_wdata_d = upd_wdata;
                    state_d     = ST_ACCESS;
                end else if (fru_elig_s) begin
                    gnt_d       = 1'b1;
                    rr_d        = 1'b0;
                    wr_d        = 1'b0;
                    oor_d       = ~fru_in_s;
                    mem_addr_d  = fru_addr_s;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 2'b00;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (clear_start) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (wr_q) begin
                    // Only the update engine can write.
                    upd_ack_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (clear_start) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (gnt_q) begin
                    fru_rdata_d = oor_q ? 2'b00 : mem_rdata;
                    fru_ack_d   = 1'b1;
                end else begin
                    upd_rdata_d = oor_q ? 2'b00 : mem_rdata;
                    upd_ack_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (mem_addr_q == LAST_ADDR) begin
                    mem_we_d     = 1'b0;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    mem_we_d   = 1'b1;
                    state_d    = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            pend_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 2'b00;
            upd_ack_q    <= 1'b0;
            upd_rdata_q  <= 2'b00;
            fru_ack_q    <= 1'b0;
            fru_rdata_q  <= 2'b00;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            wr_q         <= wr_d;
            oor_q        <= oor_d;
            pend_q       <= pend_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            upd_ack_q    <= upd_ack_d;
            upd_rdata_q  <= upd_rdata_d;
            fru_ack_q    <= fru_ack_d;
            fru_rdata_q  <= fru_rdata_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign upd_ack    = upd_ack_q;
    assign upd_rdata  = upd_rdata_q;
    assign fru_ack    = fru_ack_q;
    assign fru_rdata  = fru_rdata_q;
    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mapa_arbiter.md
Name: mapa_arbiter

Overview:
Owns the single-port tile-map RAM (MAPA_WIDTH x MAPA_HEIGHT cells, 2-bit tile codes: 00 empty, 01 snake, 10 fruit, 11 obstacle). It serialises accesses from the update engine (read/write) and the fruit spawner (read-only probes). It also runs a built-in full-map clear sweep. The block sits between the game logic and the map RAM, converting (x,y) coordinates to linear addresses.

Parameters:
MAPA_WIDTH, 40, tiles per row
MAPA_HEIGHT, 30, tiles per column
ADDR_W, 11, RAM address width; must satisfy 2^ADDR_W >= MAPA_WIDTH*MAPA_HEIGHT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; reset==0 resets the block on the rising clk edge
upd_req  in  1  update engine request; held until upd_ack
upd_we  in  1  1 = write, 0 = read; stable while upd_req is high
upd_x  in  10  tile column
upd_y  in  10  tile row
upd_wdata  in  2  write tile code
upd_ack  out  1  one-cycle completion pulse
upd_rdata  out  2  read result; valid while upd_ack=1 and held until the next update read
fru_req  in  1  fruit spawner read request; held until fru_ack
fru_x  in  10  tile column
fru_y  in  10  tile row
fru_ack  out  1  one-cycle completion pulse
fru_rdata  out  2  read result; valid while fru_ack=1 and held until the next fruit read
clear_start  in  1  pulse: start a full-map clear
clear_busy  out  1  high while the sweep runs
clear_done  out  1  one-cycle pulse after the last cell is written
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address, y*MAPA_WIDTH + x
mem_wdata  out  2  RAM write data
mem_rdata  in  2  RAM read data; synchronous RAM, valid 1 cycle after the address edge

Behaviour:
- All outputs are registered.
- Reset values: every output is 0. State is IDLE, round-robin pointer is set to update, and any pending clear is dropped. Reset in any state aborts the operation in flight without issuing an ack.
- States: IDLE, ACCESS, RDWAIT, CLEAR.
- IDLE, priority order:
  - A clear (pending or clear_start this cycle) wins: set mem_addr=0, mem_we=1, mem_wdata=00, then go to CLEAR.
  - Otherwise choose among eligible requesters by round-robin. The pointer favours the requester not granted last; at reset it favours update.
  - A requester whose ack is high this cycle is ineligible. Requesters drop req the cycle after ack.
  - On grant: register mem_addr, mem_we, mem_wdata and the grant id, then go to ACCESS.
- ACCESS:
  - mem_we is cleared at the next edge.
  - Write: ack rises at the next edge and the block returns to IDLE. Total latency is 2 cycles from the req sample edge to ack high.
  - Read: go to RDWAIT.
- RDWAIT: capture mem_rdata into upd_rdata or fru_rdata, raise the matching ack, return to IDLE. Read latency is 3 cycles.
- Out-of-range coordinates (x >= MAPA_WIDTH or y >= MAPA_HEIGHT):
  - Writes are suppressed (mem_we stays 0).
  - Reads return 00.
  - Ack timing is unchanged.
- fru_req is always treated as a read.
- CLEAR:
  - Writes 00 to one cell per cycle at addresses 0..MAPA_WIDTH*MAPA_HEIGHT-1, ascending; clear_busy=1 throughout.
  - After the last address: mem_we=0, clear_busy=0, clear_done pulses for 1 cycle, return to IDLE.
  - Total: W*H write cycles plus 1 done cycle.
- clear_start during CLEAR is ignored.
- clear_start during ACCESS or RDWAIT is latched as pending. The current access completes first, then the clear runs.
- Requests that arrive during CLEAR wait; no acks are issued until the sweep finishes.
- Simultaneous upd_req and fru_req in IDLE: the round-robin winner is served first and the other requester is served immediately after.
- Address arithmetic is done at ADDR_W bits with no wrap. For in-range coordinates the maximum address is W*H-1 = 1199.

Test Plan:
1. Reset held 3 cycles, then released with no requests -> all outputs 0 and mem_we never asserted.
2. Update write (upd_we=1, x=10, y=10, wdata=01) -> mem_addr=410 with mem_we=1 for exactly 1 cycle, upd_ack 2 cycles after the sample edge. A following read of (10,10) -> upd_rdata=01 with upd_ack at +3.
3. upd_req and fru_req asserted in the same cycle after reset, fru reading (13,13) -> update served first, then fruit (address 533). Repeating the collision alternates the winner each time.
4. clear_start pulse -> exactly 1200 consecutive write cycles covering addresses 0..1199 with data 00, clear_busy high throughout, clear_done pulses once. A upd_req raised mid-sweep is acked only after clear_done.
5. Write with x=40, y=5 -> no mem_we; upd_ack still arrives at +2. Read with y=30 -> upd_rdata=00 at +3.
6. Reset asserted during RDWAIT of a fruit read -> no fru_ack, all outputs 0 on the next cycle. A pending clear latched before the reset is not executed.
